// File: rtl/demux_rr_sched_if.sv
// Stream and demux-control bundle between one producer, the round-robin scheduler and four consumers.
// master: producer/consumer side; slave: the scheduler.
interface demux_rr_sched_if #(
  parameter int unsigned DATA_W = 8
);
  logic [3:0]        en_mask;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic [3:0]        out_valid;
  logic [3:0]        out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic [1:0]        s;
  logic              busy;

  modport master (
    output en_mask, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, s, busy
  );

  modport slave (
    input  en_mask, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, s, busy
  );
endinterface

// File: rtl/demux_rr_sched.sv
// Round-robin burst scheduler steering one stream onto a 1x4 demux via registered select s.
// Optional burst cap enabled by defining DEMUX_RR_SCHED_BURST_CAP_EN.
module demux_rr_sched #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BEATS = 16
) (
  input logic              clk,
  input logic              rst,
  demux_rr_sched_if.slave  bus
);

  typedef enum logic {IDLE, XFER} state_t;

  // Elaboration-time range guard on the burst cap
  if (MAX_BEATS < 1 || MAX_BEATS > 255) begin : g_bad_max_beats
    $error("MAX_BEATS out of range 1..255");
  end

  state_t            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        s_q, s_d;
  logic              pick_found_c;
  logic [1:0]        pick_c;
  logic [1:0]        idx_c;
  logic              cap_c;
  logic              in_ready_c;
  logic [3:0]        out_valid_c;
  logic              out_last_c;
  logic [DATA_W-1:0] data_c;

  // First enabled channel scanning upward from ptr+1
  always_comb begin
    pick_found_c = 1'b0;
    pick_c       = 2'd0;
    idx_c        = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx_c = ptr_q + 2'(i + 1);
      if (!pick_found_c && bus.en_mask[idx_c]) begin
        pick_found_c = 1'b1;
        pick_c       = idx_c;
      end
    end
  end

`ifdef DEMUX_RR_SCHED_BURST_CAP_EN
  logic [7:0] beat_cnt_q;

  // Beats accepted in the current burst, saturating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q <= 8'd0;
    end else if (state_q == IDLE) begin
      beat_cnt_q <= 8'd0;
    end else if (bus.in_valid && in_ready_c && beat_cnt_q != 8'd255) begin
      beat_cnt_q <= beat_cnt_q + 8'd1;
    end
  end

  assign cap_c = (beat_cnt_q == 8'(MAX_BEATS - 1));
`else
  assign cap_c = 1'b0;
`endif

  // Next state and combinational steering
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    s_d         = s_q;
    in_ready_c  = 1'b0;
    out_valid_c = 4'b0000;
    out_last_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && pick_found_c) begin
          s_d     = pick_c;
          state_d = XFER;
        end
      end
      XFER: begin
        in_ready_c       = bus.out_ready[s_q];
        out_valid_c[s_q] = bus.in_valid;
        out_last_c       = bus.in_last | cap_c;
        if (bus.in_valid && in_ready_c && (bus.in_last || cap_c)) begin
          ptr_d   = s_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd3;
      s_q     <= 2'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      s_q     <= s_d;
    end
  end

  assign data_c        = bus.in_data;
  assign bus.out_data  = data_c;
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_last  = out_last_c;
  assign bus.s         = s_q;
  assign bus.busy      = (state_q == XFER);

endmodule

// File: tb/tb_demux_rr_sched.sv
// Directed scoreboard bench for demux_rr_sched; honours DEMUX_RR_SCHED_BURST_CAP_EN with MAX_BEATS=4.
module tb_demux_rr_sched;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned MAX_BEATS = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  demux_rr_sched_if #(.DATA_W(DATA_W)) bus ();

  demux_rr_sched #(.DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0] ch;
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [1:0] m_ptr;
  logic [1:0] m_ch;
  logic       m_in_burst;
  int         m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] model_pick(input logic [1:0] p, input logic [3:0] m);
    logic [1:0] c;
    for (int i = 1; i <= 4; i++) begin
      c = p + 2'(i);
      if (m[c]) return c;
    end
    return 2'd0;
  endfunction

  // Drive one beat; the model decides its channel and burst end, the DUT transfer pops it
  task automatic send_beat(input logic [7:0] d, input logic last, input int stall);
    exp_t       e;
    logic       first;
    logic       done;
    logic [3:0] oh;
    first = !m_in_burst;
    if (first) begin
      m_ch       = model_pick(m_ptr, bus.en_mask);
      m_in_burst = 1'b1;
      m_cnt      = 0;
    end
    m_cnt++;
    e.ch   = m_ch;
    e.data = d;
    e.last = last;
`ifdef DEMUX_RR_SCHED_BURST_CAP_EN
    if (m_cnt == int'(MAX_BEATS)) e.last = 1'b1;
`endif
    if (e.last) begin
      m_in_burst = 1'b0;
      m_ptr      = m_ch;
    end
    sb.push_back(e);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    oh = 4'b0001 << e.ch;
    if (first) begin
      @(negedge clk);
      chk("bubble_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bubble_out_valid", 32'(bus.out_valid), 32'd0);
      @(posedge clk); #1;
    end
    if (stall > 0) begin
      bus.out_ready = ~oh;
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
        chk("stall_out_data", 32'(bus.out_data), 32'(d));
        chk("stall_out_valid", 32'(bus.out_valid), 32'(oh));
        @(posedge clk); #1;
      end
      bus.out_ready = 4'b1111;
    end
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        e  = sb.pop_front();
        oh = 4'b0001 << e.ch;
        chk("xfer_out_valid", 32'(bus.out_valid), 32'(oh));
        chk("xfer_s", 32'(bus.s), 32'(e.ch));
        chk("xfer_out_data", 32'(bus.out_data), 32'(e.data));
        chk("xfer_out_last", 32'(bus.out_last), 32'(e.last));
        chk("xfer_busy", 32'(bus.busy), 32'd1);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) chk("xfer_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  initial begin
    logic [3:0] m;
    rst           = 1'b1;
    bus.en_mask   = 4'b1111;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 4'b1111;
    m_ptr         = 2'd3;
    m_ch          = 2'd0;
    m_in_burst    = 1'b0;
    m_cnt         = 0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
    chk("rst_s", 32'(bus.s), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Rotation over four 3-beat bursts, data 0x10..0x1B
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 3; i++)
        send_beat(8'(8'h10 + 3 * b + i), (i == 2), 0);

    // Backpressure on channel 0 for 5 cycles before beat 2
    send_beat(8'h20, 1'b0, 0);
    send_beat(8'h21, 1'b0, 5);
    send_beat(8'h22, 1'b1, 0);

    // Disabled channels skipped: grants 1,3,1
    bus.en_mask = 4'b1010;
    for (int i = 0; i < 3; i++) send_beat(8'(8'h30 + i), 1'b1, 0);
    chk("skip_ptr_model", 32'(m_ptr), 32'd1);

    // Granted channel masked off mid-burst
    bus.en_mask = 4'b1111;
    send_beat(8'h60, 1'b0, 0);
    m = bus.en_mask & ~(4'b0001 << m_ch);
    bus.en_mask = m;
    send_beat(8'h61, 1'b0, 0);
    send_beat(8'h62, 1'b1, 0);

    // Empty mask holds IDLE
    bus.en_mask  = 4'b0000;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("empty_in_ready", 32'(bus.in_ready), 32'd0);
      chk("empty_busy", 32'(bus.busy), 32'd0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;

    // Asynchronous reset in the middle of a channel 2 burst
    bus.en_mask = 4'b0100;
    send_beat(8'h40, 1'b0, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h41;
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    chk("pre_rst_s", 32'(bus.s), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_s", 32'(bus.s), 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst        = 1'b0;
    sb.delete();
    m_ptr      = 2'd3;
    m_in_burst = 1'b0;
    bus.en_mask = 4'b1111;

    // 6-beat burst: cap splits it 4+2 across channels 0,1; otherwise all on channel 0
    for (int i = 0; i < 6; i++) send_beat(8'(8'h50 + i), (i == 5), 0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
